// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit for the pipelined MIPS core.
// IF side: 2^IDX_W-entry saturating-counter predictor plus target formation.
// EX side: resolves BEQ/BNE/J/JAL, trains the table, and issues a registered
// redirect on mispredict. After reset, a small FSM walks the table, writing
// the weak-not-taken value into one entry per cycle.
module branch_predict_unit #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [5:0]        if_opcode,
  input  logic [25:0]       if_imm,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [5:0]        ex_opcode,
  input  logic [25:0]       ex_imm,
  input  logic [31:0]       ex_rs,
  input  logic [31:0]       ex_rt,
  input  logic              ex_pred_taken,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic              init_done,
  output logic [31:0]       mispredict_cnt
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [5:0]       OP_J     = 6'h02;
  localparam logic [5:0]       OP_JAL   = 6'h03;
  localparam logic [5:0]       OP_BEQ   = 6'h04;
  localparam logic [5:0]       OP_BNE   = 6'h05;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic {S_INIT, S_READY} state_t;

  // pc+4 + sign-extended word offset, wrapping at 2^ADDR_W
  function automatic logic [ADDR_W-1:0] br_target(input logic [ADDR_W-1:0] pc,
                                                  input logic [25:0] imm);
    logic [ADDR_W-1:0] off;
    off = {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};
    return pc + ADDR_W'(4) + off;
  endfunction

  // Region bits of pc+4 above bit 27 combined with the 26-bit word index
  function automatic logic [ADDR_W-1:0] jmp_target(input logic [ADDR_W-1:0] pc,
                                                   input logic [25:0] imm);
    logic [ADDR_W-1:0] pc4;
    pc4 = pc + ADDR_W'(4);
    return (pc4 & ({ADDR_W{1'b1}} << 28)) | ADDR_W'({imm, 2'b00});
  endfunction

  // Saturating up/down step of a predictor counter
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic up);
    if (up)
      return (c == '1) ? c : c + CNT_W'(1);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  r_table [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_init_wr;
  logic [IDX_W-1:0]  r_init_idx;
  logic              r_init_done;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_link_valid;
  logic [ADDR_W-1:0] r_link_addr;
  logic [31:0]       r_mp_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic              w_if_is_j;
  logic              w_if_is_br;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_ex_is_j;
  logic              w_ex_is_br;
  logic              w_ex_live;
  logic              w_ex_taken;
  logic [ADDR_W-1:0] w_ex_target;
  logic [ADDR_W-1:0] w_ex_pc4;
  logic              w_mispredict;
  logic              w_train;

  // IF-side decode and prediction; table is read before any same-cycle write
  assign w_if_idx    = if_pc[IDX_W+1:2];
  assign w_if_is_j   = (if_opcode == OP_J) || (if_opcode == OP_JAL);
  assign w_if_is_br  = (if_opcode == OP_BEQ) || (if_opcode == OP_BNE);
  assign pred_taken  = if_valid &
                       (w_if_is_j | (w_if_is_br & r_table[w_if_idx][CNT_W-1] & r_init_done));
  assign pred_target = !pred_taken ? if_pc + ADDR_W'(4) :
                       w_if_is_j   ? jmp_target(if_pc, if_imm) :
                                     br_target(if_pc, if_imm);

  // EX-side resolution; a pending redirect squashes the wrong-path instruction
  assign w_ex_idx     = ex_pc[IDX_W+1:2];
  assign w_ex_is_j    = (ex_opcode == OP_J) || (ex_opcode == OP_JAL);
  assign w_ex_is_br   = (ex_opcode == OP_BEQ) || (ex_opcode == OP_BNE);
  assign w_ex_live    = ex_valid & ~r_redirect_valid;
  assign w_ex_taken   = w_ex_is_j |
                        ((ex_opcode == OP_BEQ) & (ex_rs == ex_rt)) |
                        ((ex_opcode == OP_BNE) & (ex_rs != ex_rt));
  assign w_ex_pc4     = ex_pc + ADDR_W'(4);
  assign w_ex_target  = w_ex_is_j ? jmp_target(ex_pc, ex_imm) : br_target(ex_pc, ex_imm);
  assign w_mispredict = w_ex_live & (w_ex_taken != ex_pred_taken);
  assign w_train      = w_ex_live & w_ex_is_br & (r_state == S_READY);

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign link_valid     = r_link_valid;
  assign link_addr      = r_link_addr;
  assign init_done      = r_init_done;
  assign mispredict_cnt = r_mp_cnt;

  // FSM state register; reset always restarts initialisation
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: INIT writes one entry per cycle until the last index
  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_wr = 1'b1;
        if (r_init_idx == IDX_LAST) w_state_nxt = S_READY;
      end
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Init walk index and registered completion flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else if (w_init_wr) begin
      r_init_idx <= r_init_idx + IDX_W'(1);
      if (r_init_idx == IDX_LAST) r_init_done <= 1'b1;
    end
  end

  // Counter table: init writes during INIT, training only once READY
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_wr)
        r_table[r_init_idx] <= CNT_INIT;
      else if (w_train)
        r_table[w_ex_idx] <= sat_step(r_table[w_ex_idx], w_ex_taken);
    end
  end

  // Registered redirect, JAL link and saturating mispredict count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_link_valid     <= 1'b0;
      r_link_addr      <= '0;
      r_mp_cnt         <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_ex_taken ? w_ex_target : w_ex_pc4;
        if (r_mp_cnt != '1) r_mp_cnt <= r_mp_cnt + 32'd1;
      end
      r_link_valid <= w_ex_live & (ex_opcode == OP_JAL);
      if (w_ex_live && ex_opcode == OP_JAL) r_link_addr <= w_ex_pc4;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_branch_predict_unit;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 2;
  localparam int DEPTH  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [5:0]  if_opcode;
  logic [25:0] if_imm;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [5:0]  ex_opcode;
  logic [25:0] ex_imm;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_valid;
  logic [31:0] link_addr;
  logic        init_done;
  logic [31:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_opcode(if_opcode), .if_imm(if_imm),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pred_taken(ex_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_valid(link_valid), .link_addr(link_addr),
    .init_done(init_done), .mispredict_cnt(mispredict_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          m_cnt [DEPTH];
  bit          m_init_done;
  int          m_init_left;
  bit          m_rv;
  logic [31:0] m_rpc;
  bit          m_lv;
  logic [31:0] m_la;
  longint      m_mc;

  function automatic bit is_jump(input logic [5:0] op);
    return op == 6'h02 || op == 6'h03;
  endfunction

  function automatic bit is_cond(input logic [5:0] op);
    return op == 6'h04 || op == 6'h05;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [5:0] op,
                                             input logic [25:0] imm);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    if (is_jump(op)) return {pc4[31:28], imm, 2'b00};
    off = int'($signed(imm[15:0]));
    return pc4 + 32'(off * 4);
  endfunction

  function automatic bit ref_pred(input bit v, input logic [31:0] pc, input logic [5:0] op);
    if (!v) return 1'b0;
    if (is_jump(op)) return 1'b1;
    return is_cond(op) && m_init_done && (m_cnt[idx_of(pc)] >= 2);
  endfunction

  // Advances the model by one clock using the inputs currently driven
  function automatic void model_clock();
    bit          live, act, miss;
    logic [31:0] pc4;
    int          i;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_cnt[k] = 1;
      m_init_done = 1'b0;
      m_init_left = DEPTH;
      m_rv = 1'b0; m_rpc = '0; m_lv = 1'b0; m_la = '0; m_mc = 0;
      return;
    end
    live = ex_valid && !m_rv;
    act  = is_jump(ex_opcode) || (ex_opcode == 6'h04 && ex_rs == ex_rt) ||
           (ex_opcode == 6'h05 && ex_rs != ex_rt);
    pc4  = ex_pc + 32'd4;
    miss = live && (act != ex_pred_taken);
    if (miss) begin
      m_rpc = act ? ref_target(ex_pc, ex_opcode, ex_imm) : pc4;
      if (m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    m_rv = miss;
    m_lv = live && ex_opcode == 6'h03;
    if (m_lv) m_la = pc4;
    if (live && is_cond(ex_opcode) && m_init_done) begin
      i = idx_of(ex_pc);
      if (act) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      else     m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end
    if (!m_init_done) begin
      m_init_left--;
      if (m_init_left == 0) m_init_done = 1'b1;
    end
  endfunction

  // One clock: check prediction, clock, then check registered outputs
  task automatic cyc();
    bit          pt;
    logic [31:0] tg;
    #1;
    pt = ref_pred(if_valid, if_pc, if_opcode);
    tg = pt ? ref_target(if_pc, if_opcode, if_imm) : if_pc + 32'd4;
    check("pred_taken", pred_taken, pt);
    check("pred_target", pred_target, tg);
    @(posedge clk);
    model_clock();
    #1;
    check("redirect_valid", redirect_valid, m_rv);
    check("redirect_pc", redirect_pc, m_rpc);
    check("link_valid", link_valid, m_lv);
    check("link_addr", link_addr, m_la);
    check("init_done", init_done, m_init_done);
    check("mispredict_cnt", mispredict_cnt, 64'(m_mc));
  endtask

  task automatic set_if(input bit v, input logic [31:0] pc, input logic [5:0] op,
                        input logic [25:0] imm);
    if_valid = v; if_pc = pc; if_opcode = op; if_imm = imm;
  endtask

  task automatic set_ex(input bit v, input logic [31:0] pc, input logic [5:0] op,
                        input logic [25:0] imm, input logic [31:0] rs,
                        input logic [31:0] rt, input bit pt);
    ex_valid = v; ex_pc = pc; ex_opcode = op; ex_imm = imm;
    ex_rs = rs; ex_rt = rt; ex_pred_taken = pt;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 6'h02;
      1: return 6'h03;
      2: return 6'h04;
      3: return 6'h05;
      4: return 6'h00;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    int          seen;
    longint      mc0;
    logic [31:0] pc, a;
    logic [5:0]  op;

    rst = 1'b1;
    set_if(1'b0, '0, '0, '0);
    set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    model_clock();
    #1;
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_link_valid", link_valid, 0);
    check("rst_link_addr", link_addr, 0);
    check("rst_mispredict_cnt", mispredict_cnt, 0);
    check("rst_init_done", init_done, 0);
    rst = 1'b0;

    // Initialisation: random lookups, early EX traffic must not train
    seen = 0;
    for (int k = 1; k <= 80; k++) begin
      op = (k % 2 == 0) ? 6'h04 : 6'h02;
      set_if(1'b1, $urandom & 32'h0000_00FC, op, 26'($urandom));
      if (k <= 60)
        set_ex($urandom_range(0, 1) == 1, $urandom & 32'h0000_00FC, 6'h04, 26'($urandom),
               32'd3, ($urandom_range(0, 1) == 1) ? 32'd3 : 32'd4, $urandom_range(0, 1) == 1);
      else
        set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
      if (k == 10) begin
        #1;
        if (op == 6'h04) check("init_beq_nt", pred_taken, 0);
        else             check("init_j_t", pred_taken, 1);
      end
      cyc();
      if (init_done && seen == 0) begin
        seen = k;
        check("init_latency", k, 64);
      end
    end
    if (seen == 0) check("init_latency_timeout", 0, 64);

    // Training a BEQ at 0x100 up to strongly taken
    set_if(1'b0, '0, '0, '0);
    mc0 = m_mc;
    set_ex(1'b1, 32'h100, 6'h04, 26'h0004, 32'd7, 32'd7, 1'b0);
    cyc();
    check("trn1_redirect_valid", redirect_valid, 1);
    check("trn1_redirect_pc", redirect_pc, 32'h114);
    check("trn1_count", mispredict_cnt, 64'(mc0 + 1));
    set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
    cyc();
    set_ex(1'b1, 32'h100, 6'h04, 26'h0004, 32'd7, 32'd7, 1'b0);
    cyc();
    set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
    cyc();
    set_if(1'b1, 32'h100, 6'h04, 26'h0004);
    #1;
    check("trn2_pred_taken", pred_taken, 1);
    check("trn2_pred_target", pred_target, 32'h114);
    cyc();

    // BNE backward, correctly predicted taken
    set_if(1'b1, 32'h200, 6'h05, 26'h0FFFE);
    #1;
    check("bne_pred_target", pred_target, 32'h1FC);
    set_ex(1'b1, 32'h200, 6'h05, 26'h0FFFE, 32'd1, 32'd2, 1'b1);
    cyc();
    check("bne_no_redirect", redirect_valid, 0);
    check("bne_count", mispredict_cnt, 64'(mc0 + 2));
    check("bne_sat", m_cnt[0], 3);

    // Not-taken mispredict, following instruction is squashed
    set_if(1'b0, '0, '0, '0);
    set_ex(1'b1, 32'h300, 6'h04, 26'h0008, 32'd1, 32'd2, 1'b1);
    cyc();
    check("nt_redirect_pc", redirect_pc, 32'h304);
    set_ex(1'b1, 32'h500, 6'h03, 26'h0000123, 32'd0, 32'd0, 1'b0);
    cyc();
    check("squash_redirect", redirect_valid, 0);
    check("squash_link", link_valid, 0);

    // JAL with link and redirect
    set_ex(1'b1, 32'h0400_0010, 6'h03, 26'h0000040, 32'd0, 32'd0, 1'b0);
    cyc();
    check("jal_link_valid", link_valid, 1);
    check("jal_link_addr", link_addr, 32'h0400_0014);
    check("jal_redirect_pc", redirect_pc, 32'h0000_0100);
    set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
    cyc();

    // Same-cycle train and lookup of index 5
    set_if(1'b1, 32'h14, 6'h04, 26'h0010);
    set_ex(1'b1, 32'h14, 6'h04, 26'h0010, 32'd9, 32'd9, 1'b1);
    #1;
    check("coll_old", pred_taken, 0);
    cyc();
    set_ex(1'b0, '0, '0, '0, '0, '0, 1'b0);
    #1;
    check("coll_new", pred_taken, 1);
    check("coll_new_target", pred_target, 32'h58);
    cyc();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      pc = $urandom & 32'hF000_00FC;
      set_if($urandom_range(0, 3) != 0, pc, rand_op(), 26'($urandom));
      a  = ($urandom_range(0, 1) == 1) ? pc : ($urandom & 32'hF000_00FC);
      op = rand_op();
      set_ex($urandom_range(0, 3) != 0, a, op, 26'($urandom), 32'($urandom_range(0, 3)),
             32'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1) ? ref_pred(1'b1, a, op) : ($urandom_range(0, 1) == 1));
      cyc();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch/jump decode block in the pipelined MIPS core.
- IF side: predicts BEQ/BNE outcome from a table of 2^IDX_W saturating counters and forms full jump/branch target addresses.
- EX side: resolves the branch, trains the table, and issues a registered redirect on mispredict.
- Adds BNE, JAL link output, a table-initialisation FSM and a mispredict counter.

Parameters:
- ADDR_W, 32, PC/target width (≥28).
- IDX_W, 6, predictor index bits; table depth = 2^IDX_W.
- CNT_W, 2, counter width (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF lookup request.
- if_pc  in  ADDR_W  PC of the IF instruction.
- if_opcode  in  6  IF instruction [31:26].
- if_imm  in  26  IF instruction [25:0].
- pred_taken  out  1  combinational prediction.
- pred_target  out  ADDR_W  combinational predicted target.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  ADDR_W  EX-stage PC.
- ex_opcode  in  6  EX-stage opcode.
- ex_imm  in  26  EX-stage immediate field.
- ex_rs  in  32  forwarded Rs value.
- ex_rt  in  32  forwarded Rt value.
- ex_pred_taken  in  1  pred_taken piped down with the instruction.
- redirect_valid  out  1  registered; flush and refetch.
- redirect_pc  out  ADDR_W  registered refetch address.
- link_valid  out  1  registered; JAL write to r31.
- link_addr  out  ADDR_W  registered; ex_pc+4.
- init_done  out  1  table initialisation complete.
- mispredict_cnt  out  32  saturating mispredict count.

Behaviour:
- Opcodes: J=6'h02, JAL=6'h03, BEQ=6'h04, BNE=6'h05; all others are non-branch.
- Branch target = pc+4 + (sign-extend(imm[15:0]) << 2), computed modulo 2^ADDR_W.
- Jump target = {(pc+4)[ADDR_W-1:28], imm[25:0], 2'b00}.
- Index = pc[IDX_W+1:2].
- Counter predicts taken when its MSB = 1.
- Reset/weak-not-taken value: 2^(CNT_W-1)-1 (2'b01 for CNT_W=2).
- FSM INIT:
  - Entered on rst; walks init_idx from 0 to 2^IDX_W-1, writing the reset value to one entry per cycle.
  - After the last write, goes to READY; init_done rises the cycle after the last write and is registered.
  - INIT takes exactly 2^IDX_W cycles after rst deasserts.
  - During INIT: BEQ/BNE predict not-taken, table training is dropped, J/JAL still predict taken, redirects still operate.
- FSM READY: normal operation; leaves only on rst.
- rst asserted mid-INIT or in READY: restart INIT at index 0.
- Reset values: redirect_valid=0, redirect_pc=0, link_valid=0, link_addr=0, mispredict_cnt=0, init_done=0.
- IF prediction (combinational from registered state):
  - pred_taken = if_valid & (J|JAL | ((BEQ|BNE) & counter MSB & init_done)).
  - pred_target = the matching target when pred_taken, else if_pc+4.
- EX resolution:
  - actual_taken = J|JAL | (BEQ & rs==rt) | (BNE & rs!=rt).
  - Non-branch instructions are never taken.
- Mispredict = ex_valid & (actual_taken != ex_pred_taken). Next cycle: redirect_valid=1, redirect_pc = actual_taken ? target : ex_pc+4. Single-cycle pulse.
- Wrong-path squash: in any cycle where redirect_valid=1, ex_valid is ignored (no training, no redirect, no link, no count).
- Training:
  - ex_valid & (BEQ|BNE) & READY → counter[ex idx] +1 if taken, −1 if not.
  - Saturates at all-ones and at 0.
- Simultaneous IF lookup and EX training of the same index in one cycle: the lookup sees the old value (read-before-write).
- JAL: link_valid=1 and link_addr=ex_pc+4 the cycle after EX, whether or not it redirects.
- mispredict_cnt: +1 per mispredict; holds at 32'hFFFFFFFF.

Test Plan:
- Init: rst 1 cycle, IDX_W=6 → init_done=1 exactly 64 cycles after rst falls. BEQ lookup during INIT gives pred_taken=0; J lookup gives pred_taken=1.
- Training: BEQ at pc=0x100, imm=0x0004, rs=rt, ex_pred_taken=0.
  - 1st resolve → redirect_valid=1, redirect_pc=0x114, count=1.
  - 2nd same → counter=2'b11; next IF lookup of 0x100 gives pred_taken=1, pred_target=0x114.
- BNE backward: pc=0x200, imm=0xFFFE, rs≠rt, ex_pred_taken=1 → no redirect, count unchanged, counter saturates at 2'b11.
- Not-taken mispredict: BEQ pc=0x300, rs≠rt, ex_pred_taken=1 → redirect_pc=0x304. A valid EX instruction in the following cycle is ignored.
- JAL: pc=0x0400_0010, imm=0x0000040 → link_addr=0x0400_0014, link_valid=1. With ex_pred_taken=0, redirect_pc=0x0000_0100.
- Same-cycle collision: train index 5 up while IF looks up index 5 → IF uses the pre-update counter; the following cycle reflects the update.
